cpu_prog_loader: RTL and testbench
==================================

CPU_PROG_LOADER -- requirements
Module: cpu_prog_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 13, instruction word width in bits.
REQ-002 SHALL have parameter IWIDTH, default 5, opcode field width; AWIDTH = WIDTH-IWIDTH (8) is the program address width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port IN_DATA  input  8  host byte stream.
REQ-007 SHALL have port IN_VALID  input  1  host byte valid.
REQ-008 SHALL have port IN_LAST  input  1  marks final byte of the program.
REQ-009 SHALL have port IN_READY  output  1  loader accepts byte; transfer occurs when IN_VALID and IN_READY are both 1 at a clock edge.
REQ-010 SHALL have port ADDR  input  AWIDTH  fetch address from the program counter.
REQ-011 SHALL have port DATA  output  WIDTH  instruction at ADDR, replacing the fixed ROM in the fetch path.
REQ-012 SHALL have port CPU_HOLD  output  1  drives program-counter reset; 1 keeps the CPU halted.
REQ-013 SHALL have port LOAD_DONE  output  1  program loaded successfully.
REQ-014 SHALL have port LOAD_ERR  output  1  sticky load-error flag.
REQ-015 SHALL have port WORD_CNT  output  AWIDTH+1  number of words written in the current load.

Function
REQ-016 SHALL implement states IDLE, LO, HI, CHK, DONE; CHK exists only under the Configuration macro.
REQ-017 SHALL move IDLE->LO or DONE->LO on START, clearing WORD_CNT, LOAD_DONE, LOAD_ERR and the write pointer to 0 on that edge.
REQ-018 SHALL ignore START in LO, HI and CHK.
REQ-019 SHALL drive IN_READY=1 only in LO, HI and CHK.
REQ-020 SHALL, on a byte accepted in LO, latch it as instruction bits [7:0] and go to HI.
REQ-021 SHALL, on a byte accepted in HI, write {IN_DATA[4:0], low byte} to memory at the write pointer on that edge, increment pointer and WORD_CNT, and go to LO.
REQ-022 SHALL set LOAD_ERR if IN_DATA[7:5] is nonzero in HI; the word is still written.
REQ-023 SHALL, when IN_LAST accompanies a HI byte, go to DONE (CHK with macro) after the write.
REQ-024 SHALL, when IN_LAST accompanies a LO byte, set LOAD_ERR and go to DONE without writing.
REQ-025 SHALL, after writing address 2^AWIDTH-1 without IN_LAST, set LOAD_ERR and go to DONE; the pointer never wraps.
REQ-026 SHALL drive DATA = mem[ADDR] combinationally (zero latency); a same-cycle write to ADDR is visible only after the edge.
REQ-027 SHALL drive LOAD_DONE=1 only in DONE with LOAD_ERR=0.
REQ-028 SHALL drive CPU_HOLD=0 only when LOAD_DONE=1; otherwise CPU_HOLD=1.

Reset
REQ-029 SHALL on RST=0 immediately enter IDLE with IN_READY=0, CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0, WORD_CNT=0, write pointer 0, low-byte register 0.
REQ-030 SHALL NOT reset program memory contents; reset mid-load abandons the load and leaves words already written unchanged.

Configuration
REQ-031 SHALL, with CPU_LOADER_CHECKSUM_EN defined, require one checksum byte after the IN_LAST byte in state CHK; set LOAD_ERR if it differs from the XOR of all program bytes; then go to DONE.
REQ-032 SHALL, without CPU_LOADER_CHECKSUM_EN, omit state CHK and the checksum logic; IN_LAST in HI goes directly to DONE.

Structure
REQ-033 SHALL place the state enumeration and the AWIDTH derivation in the shared package cpu_pkg.
REQ-034 SHALL instantiate one sub-module, cpu_prog_ram: single write port, asynchronous read port, 2^AWIDTH x WIDTH.

Verification
REQ-035 SHALL cover: START, then bytes 0x34,0x12 (IN_LAST on 0x12) -> mem[0]=0x1234, WORD_CNT=1, LOAD_DONE=1, CPU_HOLD=0.
REQ-036 SHALL cover: IN_VALID toggling 1/0 across a 3-word load -> exactly 3 writes at addresses 0..2, with no byte lost or duplicated.
REQ-037 SHALL cover: IN_LAST on a LO byte -> LOAD_ERR=1, WORD_CNT unchanged, CPU_HOLD=1.
REQ-038 SHALL cover: 256 words without IN_LAST -> LOAD_ERR=1 after word 256, IN_READY=0, mem[0] not overwritten.
REQ-039 SHALL cover: RST=0 during HI -> immediate IDLE, CPU_HOLD=1; a following START with a new load succeeds.
REQ-040 SHALL cover, with macro: bytes 0x01,0x02 then checksum 0x03 -> LOAD_DONE=1; checksum 0x00 -> LOAD_ERR=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the program loader: FSM state encoding and address-width derivation.
// Optional checksum stage is enabled with CPU_LOADER_CHECKSUM_EN.
package cpu_pkg;

    localparam int DEF_WIDTH  = 13;
    localparam int DEF_IWIDTH = 5;

    function automatic int addr_width(input int width, input int iwidth);
        return width - iwidth;
    endfunction

    localparam int DEF_AWIDTH = addr_width(DEF_WIDTH, DEF_IWIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StLo,
        StHi,
`ifdef CPU_LOADER_CHECKSUM_EN
        StChk,
`endif
        StDone
    } ld_state_e;

endpackage

// File: rtl/cpu_prog_ram.sv
// Program memory: one synchronous write port, one asynchronous read port, no reset.
module cpu_prog_ram #(
    parameter int WIDTH  = 13,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [2**AWIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_prog_loader.sv
// Loads a program from a host byte stream into RAM and holds the CPU until it completes.
// Define CPU_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module cpu_prog_loader
    import cpu_pkg::*;
#(
    parameter int  WIDTH  = 13,
    parameter int  IWIDTH = 5,
    localparam int AWIDTH = addr_width(WIDTH, IWIDTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    input  logic              IN_LAST,
    output logic              IN_READY,
    input  logic [AWIDTH-1:0] ADDR,
    output logic [WIDTH-1:0]  DATA,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR,
    output logic [AWIDTH:0]   WORD_CNT
);

    // Bits of the high byte that belong to the instruction word.
    localparam int HB = WIDTH - 8;
    localparam logic [AWIDTH-1:0] PTR_ONE = 1;
    localparam logic [AWIDTH:0]   CNT_ONE = 1;

    ld_state_e         state_q;
    logic [AWIDTH-1:0] wr_ptr_q;
    logic [AWIDTH:0]   word_cnt_q;
    logic [7:0]        lo_q;
    logic              err_q;
`ifdef CPU_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             ptr_full;
    logic             hi_bad;

    assign we       = (state_q == StHi) && IN_VALID;
    assign wdata    = {IN_DATA[HB-1:0], lo_q};
    assign ptr_full = &wr_ptr_q;
    assign hi_bad   = (IN_DATA >> HB) != 8'd0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            word_cnt_q <= '0;
            lo_q       <= '0;
            err_q      <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (START) begin
                        state_q    <= StLo;
                        wr_ptr_q   <= '0;
                        word_cnt_q <= '0;
                        err_q      <= 1'b0;
`ifdef CPU_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                StLo: begin
                    if (IN_VALID) begin
                        if (IN_LAST) begin
                            // A program cannot end on half a word.
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            lo_q    <= IN_DATA;
                            state_q <= StHi;
`ifdef CPU_LOADER_CHECKSUM_EN
                            csum_q  <= csum_q ^ IN_DATA;
`endif
                        end
                    end
                end
                StHi: begin
                    if (IN_VALID) begin
                        word_cnt_q <= word_cnt_q + CNT_ONE;
                        if (!ptr_full) begin
                            wr_ptr_q <= wr_ptr_q + PTR_ONE;
                        end
                        if (hi_bad) begin
                            err_q <= 1'b1;
                        end
`ifdef CPU_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ IN_DATA;
`endif
                        if (IN_LAST) begin
`ifdef CPU_LOADER_CHECKSUM_EN
                            state_q <= StChk;
`else
                            state_q <= StDone;
`endif
                        end else if (ptr_full) begin
                            // Memory exhausted before the host marked the end.
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StLo;
                        end
                    end
                end
`ifdef CPU_LOADER_CHECKSUM_EN
                StChk: begin
                    if (IN_VALID) begin
                        if (IN_DATA != csum_q) begin
                            err_q <= 1'b1;
                        end
                        state_q <= StDone;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign IN_READY = (state_q == StLo) || (state_q == StHi)
`ifdef CPU_LOADER_CHECKSUM_EN
                      || (state_q == StChk)
`endif
                      ;

    assign LOAD_DONE = (state_q == StDone) && !err_q;
    assign CPU_HOLD  = !LOAD_DONE;
    assign LOAD_ERR  = err_q;
    assign WORD_CNT  = word_cnt_q;

    cpu_prog_ram #(
        .WIDTH (WIDTH),
        .AWIDTH(AWIDTH)
    ) u_ram (
        .clk_i  (CLK),
        .we_i   (we),
        .waddr_i(wr_ptr_q),
        .wdata_i(wdata),
        .raddr_i(ADDR),
        .rdata_o(DATA)
    );

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Randomized bench for cpu_prog_loader, checked every cycle against a load-level model.
module tb_cpu_prog_loader;

    localparam int W  = 13;
    localparam int AW = 8;
    localparam int NW = 256;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [7:0]    IN_DATA = 8'h00;
    logic          IN_VALID = 1'b0;
    logic          IN_LAST = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] ADDR = '0;
    logic [W-1:0]  DATA;
    logic          CPU_HOLD;
    logic          LOAD_DONE;
    logic          LOAD_ERR;
    logic [AW:0]   WORD_CNT;

    cpu_prog_loader #(
        .WIDTH (W),
        .IWIDTH(5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_LAST  (IN_LAST),
        .IN_READY (IN_READY),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .CPU_HOLD (CPU_HOLD),
        .LOAD_DONE(LOAD_DONE),
        .LOAD_ERR (LOAD_ERR),
        .WORD_CNT (WORD_CNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Load-level model: a load is "active" while bytes are being taken, "done" once it ended.
    bit         m_active, m_done, m_err, m_chk;
    int         m_cnt, m_nbytes;
    logic [7:0] m_lo, m_csum;
    logic [W-1:0] m_mem [NW];
    bit         m_known [NW];
    bit         checking = 1'b0;
    logic [7:0] tb_x;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_chk = 0;
        m_cnt = 0; m_nbytes = 0; m_lo = 8'h00; m_csum = 8'h00;
    endtask

    task automatic model_finish();
        m_active = 0;
        m_done   = 1;
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            if (!m_active) begin
                if (START) begin
                    m_active = 1; m_done = 0; m_err = 0; m_chk = 0;
                    m_cnt = 0; m_nbytes = 0; m_csum = 8'h00;
                end
            end else if (IN_VALID) begin
                if (m_chk) begin
                    if (IN_DATA != m_csum) m_err = 1;
                    model_finish();
                end else if (m_nbytes % 2 == 0) begin
                    if (IN_LAST) begin
                        m_err = 1;
                        model_finish();
                    end else begin
                        m_lo = IN_DATA;
                        m_csum ^= IN_DATA;
                        m_nbytes++;
                    end
                end else begin
                    m_mem[m_cnt]   = W'(int'(m_lo) + int'(IN_DATA % 8'd32) * 256);
                    m_known[m_cnt] = 1;
                    if (IN_DATA >= 8'd32) m_err = 1;
                    m_csum ^= IN_DATA;
                    m_cnt++;
                    m_nbytes++;
                    if (IN_LAST) begin
`ifdef CPU_LOADER_CHECKSUM_EN
                        m_chk = 1;
`else
                        model_finish();
`endif
                    end else if (m_cnt == NW) begin
                        m_err = 1;
                        model_finish();
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            cmp("in_ready", {31'd0, IN_READY}, {31'd0, m_active});
            cmp("load_err", {31'd0, LOAD_ERR}, {31'd0, m_err});
            cmp("load_done", {31'd0, LOAD_DONE}, {31'd0, m_done && !m_err});
            cmp("cpu_hold", {31'd0, CPU_HOLD}, {31'd0, !(m_done && !m_err)});
            cmp("word_cnt", {23'd0, WORD_CNT}, m_cnt);
            if (m_known[ADDR]) cmp("data", {19'd0, DATA}, {19'd0, m_mem[ADDR]});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
        IN_VALID = 1'b0;
        START    = 1'b0;
        IN_DATA  = 8'($urandom);
        IN_LAST  = 1'($urandom);
        ADDR     = AW'($urandom);
    endtask

    task automatic start_load();
        START = 1'b1;
        tb_x  = 8'h00;
        tick();
    endtask

    task automatic send(input logic [7:0] b, input bit l, input int gap);
        IN_DATA  = b;
        IN_LAST  = l;
        IN_VALID = 1'b1;
        tb_x ^= b;
        tick();
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit l, input int gap);
        send(w[7:0], 1'b0, gap);
        send({3'b000, w[12:8]}, l, gap);
    endtask

    task automatic end_csum(input bit good);
`ifdef CPU_LOADER_CHECKSUM_EN
        send(good ? tb_x : ~tb_x, 1'b0, 0);
`else
        if (good) tb_x = 8'h00;
`endif
    endtask

    task automatic peek(input int a);
        ADDR = AW'(a);
        #1;
    endtask

    logic [W-1:0] words3 [3];

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        for (int i = 0; i < NW; i++) m_known[i] = 0;
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        cmp("rst_ready", {31'd0, IN_READY}, 0);
        cmp("rst_hold", {31'd0, CPU_HOLD}, 1);
        cmp("rst_done", {31'd0, LOAD_DONE}, 0);
        cmp("rst_err", {31'd0, LOAD_ERR}, 0);
        cmp("rst_cnt", {23'd0, WORD_CNT}, 0);
        RST = 1'b1;
        checking = 1'b1;
        tick();

        // Single word 0x1234.
        start_load();
        send(8'h34, 1'b0, 0);
        send(8'h12, 1'b1, 0);
        end_csum(1'b1);
        tick();
        peek(0);
        cmp("t1_data", {19'd0, DATA}, 32'h1234);
        cmp("t1_cnt", {23'd0, WORD_CNT}, 1);
        cmp("t1_done", {31'd0, LOAD_DONE}, 1);
        cmp("t1_hold", {31'd0, CPU_HOLD}, 0);

        // Three words with IN_VALID gaps.
        words3[0] = 13'h0abc; words3[1] = 13'h1555; words3[2] = 13'h0001;
        start_load();
        for (int i = 0; i < 3; i++) send_word(words3[i], i == 2, 1 + i % 2);
        end_csum(1'b1);
        tick();
        peek(0); cmp("t2_w0", {19'd0, DATA}, 32'h0abc);
        peek(1); cmp("t2_w1", {19'd0, DATA}, 32'h1555);
        peek(2); cmp("t2_w2", {19'd0, DATA}, 32'h0001);
        cmp("t2_cnt", {23'd0, WORD_CNT}, 3);

        // IN_LAST on a low byte.
        start_load();
        send_word(13'h0777, 1'b0, 0);
        send(8'h55, 1'b1, 0);
        tick();
        cmp("t3_err", {31'd0, LOAD_ERR}, 1);
        cmp("t3_cnt", {23'd0, WORD_CNT}, 1);
        cmp("t3_hold", {31'd0, CPU_HOLD}, 1);
        cmp("t3_ready", {31'd0, IN_READY}, 0);

        // Nonzero spare bits in the high byte: error, but word still written.
        start_load();
        send(8'h9a, 1'b0, 0);
        send(8'he1, 1'b1, 0);
        end_csum(1'b1);
        tick();
        peek(0);
        cmp("t4_data", {19'd0, DATA}, 32'h019a);
        cmp("t4_err", {31'd0, LOAD_ERR}, 1);
        cmp("t4_done", {31'd0, LOAD_DONE}, 0);

        // 256 words without IN_LAST overflow the memory.
        start_load();
        for (int i = 0; i < NW; i++) send_word(W'(i * 37 + 5), 1'b0, 0);
        tick();
        send(8'hff, 1'b0, 0);
        send(8'hff, 1'b0, 0);
        peek(0);
        cmp("t5_data0", {19'd0, DATA}, 32'h0005);
        cmp("t5_err", {31'd0, LOAD_ERR}, 1);
        cmp("t5_ready", {31'd0, IN_READY}, 0);
        cmp("t5_cnt", {23'd0, WORD_CNT}, 256);

        // Exactly 256 words with IN_LAST on the last one.
        start_load();
        for (int i = 0; i < NW; i++) send_word(W'(i * 11), i == NW - 1, 0);
        end_csum(1'b1);
        tick();
        peek(255);
        cmp("t6_data", {19'd0, DATA}, 2805);
        cmp("t6_done", {31'd0, LOAD_DONE}, 1);
        cmp("t6_cnt", {23'd0, WORD_CNT}, 256);

        // Reset while waiting for a high byte, then a fresh load.
        start_load();
        send(8'h42, 1'b0, 0);
        RST = 1'b0;
        model_reset();
        #1;
        cmp("t7_ready", {31'd0, IN_READY}, 0);
        cmp("t7_hold", {31'd0, CPU_HOLD}, 1);
        cmp("t7_cnt", {23'd0, WORD_CNT}, 0);
        tick();
        RST = 1'b1;
        tick();
        start_load();
        send_word(13'h0bee, 1'b1, 0);
        end_csum(1'b1);
        tick();
        peek(0);
        cmp("t7_data", {19'd0, DATA}, 32'h0bee);
        cmp("t7_done", {31'd0, LOAD_DONE}, 1);

`ifdef CPU_LOADER_CHECKSUM_EN
        start_load();
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b1, 0);
        send(8'h03, 1'b0, 0);
        tick();
        cmp("t8_done", {31'd0, LOAD_DONE}, 1);
        start_load();
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b1, 0);
        send(8'h00, 1'b0, 0);
        tick();
        cmp("t8_err", {31'd0, LOAD_ERR}, 1);
`endif

        // Random loads: gaps, stray STARTs, bad bits, early ends, bad checksums.
        repeat (40) begin
            int  n;
            bit  ab;
            logic [7:0] lo, hi;
            start_load();
            n  = $urandom_range(1, 12);
            ab = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!ab) begin
                    lo = 8'($urandom);
                    hi = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
                    if ($urandom_range(0, 15) == 0) begin
                        send(lo, 1'b1, $urandom_range(0, 2));
                        ab = 1'b1;
                    end else begin
                        send(lo, 1'b0, $urandom_range(0, 2));
                        if ($urandom_range(0, 7) == 0) START = 1'b1;
                        send(hi, i == n - 1, $urandom_range(0, 2));
                    end
                end
            end
            end_csum($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 3)) begin
                IN_VALID = 1'($urandom);
                tick();
            end
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
